// File: rtl/f1_pkg.sv
// F1 fetch-stage shared types:
// exception codes, ITLB FSM states and TLB entry layout.
package f1_pkg;

   localparam int TLB_VPN_W = 20;
   localparam int TLB_PPN_W = 20;

   localparam logic [1:0] EXC_NONE = 2'd0;
   localparam logic [1:0] EXC_PF   = 2'd1;
   localparam logic [1:0] EXC_X    = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DRAIN
   } itlb_state_e;

   typedef struct packed {
      logic                 valid;
      logic [TLB_VPN_W-1:0] vpn;
      logic [TLB_PPN_W-1:0] ppn;
      logic                 pcd;
      logic                 x;
   } tlb_entry_t;

endpackage

// File: rtl/itlb_cam.sv
// ITLB entry storage: fully associative array with two
// parallel compare ports and one write port.
module itlb_cam
   import f1_pkg::*;
#(
   parameter  int ENTRIES = 8,
   localparam int PTR_W   = $clog2(ENTRIES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 we,
   input  logic [PTR_W-1:0]     widx,
   input  tlb_entry_t           wdata,
   input  logic [TLB_VPN_W-1:0] vpn_e,
   input  logic [TLB_VPN_W-1:0] vpn_o,
   output logic                 hit_e,
   output logic [TLB_PPN_W-1:0] ppn_e,
   output logic                 pcd_e,
   output logic                 x_e,
   output logic                 hit_o,
   output logic [TLB_PPN_W-1:0] ppn_o,
   output logic                 pcd_o,
   output logic                 x_o
);

   tlb_entry_t ents [ENTRIES];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) ents[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < ENTRIES; i++) ents[i].valid <= 1'b0;
      end else if (we) begin
         ents[widx] <= wdata;
      end
   end

   // VPNs are unique, so OR-merging the matching entry is safe.
   always_comb begin
      hit_e = 1'b0;
      ppn_e = '0;
      pcd_e = 1'b0;
      x_e   = 1'b0;
      hit_o = 1'b0;
      ppn_o = '0;
      pcd_o = 1'b0;
      x_o   = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (ents[i].valid && ents[i].vpn == vpn_e) begin
            hit_e = 1'b1;
            ppn_e = ppn_e | ents[i].ppn;
            pcd_e = pcd_e | ents[i].pcd;
            x_e   = x_e | ents[i].x;
         end
         if (ents[i].valid && ents[i].vpn == vpn_o) begin
            hit_o = 1'b1;
            ppn_o = ppn_o | ents[i].ppn;
            pcd_o = pcd_o | ents[i].pcd;
            x_o   = x_o | ents[i].x;
         end
      end
   end

endmodule

// File: rtl/f1_itlb.sv
// F1 instruction TLB: dual-port lookup, page-walk fill FSM,
// round-robin replacement, flush and per-port fault reporting.
module f1_itlb
   import f1_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int CLC_WIDTH = 26,
   parameter int PAGE_OFF  = 12,
   parameter int ENTRIES   = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_in,
   input  logic [CLC_WIDTH-1:0]     clc_even_in,
   input  logic [CLC_WIDTH-1:0]     clc_odd_in,
   input  logic                     flush,
   output logic                     lookup_ready,
   output logic                     hit,
   output logic                     pcd,
   output logic                     exception,
   output logic [1:0]               exception_type,
   output logic [XLEN-1:0]          addr_even,
   output logic [XLEN-1:0]          addr_odd,
   output logic                     addr_even_valid,
   output logic                     addr_odd_valid,
   output logic                     ptw_req_valid,
   input  logic                     ptw_req_ready,
   output logic [XLEN-PAGE_OFF-1:0] ptw_req_vpn,
   input  logic                     ptw_resp_valid,
   input  logic [XLEN-PAGE_OFF-1:0] ptw_resp_ppn,
   input  logic                     ptw_resp_pcd,
   input  logic                     ptw_resp_x,
   input  logic                     ptw_resp_fault
);

   localparam int LINE_OFF = XLEN - CLC_WIDTH;
   localparam int LIP_W    = PAGE_OFF - LINE_OFF;
   localparam int VPN_W    = XLEN - PAGE_OFF;
   localparam int PTR_W    = $clog2(ENTRIES);

   itlb_state_e state_q, state_d;

   logic [VPN_W-1:0] vpn_e, vpn_o, vpn_q, walk_vpn;
   logic [LIP_W-1:0] lip_e, lip_o;
   logic [VPN_W-1:0] ppn_e, ppn_o;
   logic             hit_e, hit_o, pcd_e, pcd_o, x_e, x_o;
   logic [PTR_W-1:0] ptr_q;
   logic             pf_pend_q;
   logic             fill_we, pf_set;
   logic             active, start_walk, any_exc;
   logic             pf_e, pf_o, xv_e, xv_o;
   logic [1:0]       exc_e, exc_o, exc_sel;
   tlb_entry_t       fill;

   assign vpn_e = clc_even_in[CLC_WIDTH-1:LIP_W];
   assign vpn_o = clc_odd_in[CLC_WIDTH-1:LIP_W];
   assign lip_e = clc_even_in[LIP_W-1:0];
   assign lip_o = clc_odd_in[LIP_W-1:0];

   assign fill = '{valid: 1'b1, vpn: vpn_q, ppn: ptw_resp_ppn,
                   pcd: ptw_resp_pcd, x: ptw_resp_x};

   itlb_cam #(.ENTRIES(ENTRIES)) u_cam (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .we    (fill_we),
      .widx  (ptr_q),
      .wdata (fill),
      .vpn_e (vpn_e),
      .vpn_o (vpn_o),
      .hit_e (hit_e),
      .ppn_e (ppn_e),
      .pcd_e (pcd_e),
      .x_e   (x_e),
      .hit_o (hit_o),
      .ppn_o (ppn_o),
      .pcd_o (pcd_o),
      .x_o   (x_o)
   );

   assign active = valid_in & lookup_ready & ~flush;

   // A faulted walk is reported once, on the replay of the walked VPN.
   assign pf_e = pf_pend_q & ~hit_e & (vpn_e == vpn_q);
   assign pf_o = pf_pend_q & ~hit_o & (vpn_o == vpn_q);
   assign xv_e = hit_e & ~x_e;
   assign xv_o = hit_o & ~x_o;

   always_comb begin
      exc_e = EXC_NONE;
      exc_o = EXC_NONE;
      unique case (1'b1)
         pf_e:    exc_e = EXC_PF;
         xv_e:    exc_e = EXC_X;
         default: ;
      endcase
      unique case (1'b1)
         pf_o:    exc_o = EXC_PF;
         xv_o:    exc_o = EXC_X;
         default: ;
      endcase
   end

   assign exc_sel    = (exc_e != EXC_NONE) ? exc_e : exc_o;
   assign any_exc    = pf_e | pf_o | xv_e | xv_o;
   assign start_walk = active & ~any_exc & (~hit_e | ~hit_o);
   assign walk_vpn   = hit_e ? vpn_o : vpn_e;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:
            if (start_walk) state_d = S_REQ;
         S_REQ:
            if (flush)
               state_d = ptw_req_ready ? S_DRAIN : S_IDLE;
            else if (ptw_req_ready)
               state_d = S_WAIT;
         S_WAIT:
            if (flush)
               state_d = ptw_resp_valid ? S_IDLE : S_DRAIN;
            else if (ptw_resp_valid)
               state_d = S_IDLE;
         S_DRAIN:
            if (ptw_resp_valid) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      lookup_ready  = 1'b0;
      ptw_req_valid = 1'b0;
      fill_we       = 1'b0;
      pf_set        = 1'b0;
      unique case (state_q)
         S_IDLE: lookup_ready  = 1'b1;
         S_REQ:  ptw_req_valid = 1'b1;
         S_WAIT: begin
            fill_we = ptw_resp_valid & ~ptw_resp_fault & ~flush;
            pf_set  = ptw_resp_valid & ptw_resp_fault & ~flush;
         end
         default: ;
      endcase
   end

   assign ptw_req_vpn = vpn_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vpn_q     <= '0;
         ptr_q     <= '0;
         pf_pend_q <= 1'b0;
      end else begin
         if (start_walk) vpn_q <= walk_vpn;
         if (fill_we)    ptr_q <= ptr_q + PTR_W'(1);
         if (flush)
            pf_pend_q <= 1'b0;
         else if (pf_set)
            pf_pend_q <= 1'b1;
         else if (lookup_ready && valid_in)
            pf_pend_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit             <= 1'b0;
         pcd             <= 1'b0;
         exception       <= 1'b0;
         exception_type  <= EXC_NONE;
         addr_even       <= '0;
         addr_odd        <= '0;
         addr_even_valid <= 1'b0;
         addr_odd_valid  <= 1'b0;
      end else if (active) begin
         hit             <= hit_e & hit_o & x_e & x_o;
         pcd             <= (hit_e & pcd_e) | (hit_o & pcd_o);
         exception       <= any_exc;
         exception_type  <= exc_sel;
         addr_even       <= {ppn_e, lip_e, {LINE_OFF{1'b0}}};
         addr_odd        <= {ppn_o, lip_o, {LINE_OFF{1'b0}}};
         addr_even_valid <= hit_e & x_e;
         addr_odd_valid  <= hit_o & x_o;
      end else begin
         hit             <= 1'b0;
         pcd             <= 1'b0;
         exception       <= 1'b0;
         exception_type  <= EXC_NONE;
         addr_even       <= '0;
         addr_odd        <= '0;
         addr_even_valid <= 1'b0;
         addr_odd_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_f1_itlb.sv
// Bench for f1_itlb: page-table walker stub plus a
// slot-level reference model of the translation cache.
module tb_f1_itlb;

   localparam int ENT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in, flush;
   logic [25:0] clc_even_in, clc_odd_in;
   logic        lookup_ready, hit, pcd, exception;
   logic [1:0]  exception_type;
   logic [31:0] addr_even, addr_odd;
   logic        addr_even_valid, addr_odd_valid;
   logic        ptw_req_valid, ptw_req_ready;
   logic [19:0] ptw_req_vpn, ptw_resp_ppn;
   logic        ptw_resp_valid, ptw_resp_pcd, ptw_resp_x, ptw_resp_fault;

   always #5 clk = ~clk;

   f1_itlb #(.XLEN(32), .CLC_WIDTH(26), .PAGE_OFF(12), .ENTRIES(ENT)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in),
      .clc_even_in(clc_even_in), .clc_odd_in(clc_odd_in), .flush(flush),
      .lookup_ready(lookup_ready), .hit(hit), .pcd(pcd),
      .exception(exception), .exception_type(exception_type),
      .addr_even(addr_even), .addr_odd(addr_odd),
      .addr_even_valid(addr_even_valid), .addr_odd_valid(addr_odd_valid),
      .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready),
      .ptw_req_vpn(ptw_req_vpn), .ptw_resp_valid(ptw_resp_valid),
      .ptw_resp_ppn(ptw_resp_ppn), .ptw_resp_pcd(ptw_resp_pcd),
      .ptw_resp_x(ptw_resp_x), .ptw_resp_fault(ptw_resp_fault)
   );

   int total = 0;
   int bad = 0;

   logic [19:0] pt_ppn [64];
   bit          pt_pcd [64];
   bit          pt_x   [64];
   bit          pt_fault [64];

   int m_vpn [ENT];
   bit m_val [ENT];
   int m_ptr;
   int walked_q[$];
   int exp_q[$];

   logic        r_hit, r_pcd, r_exc, r_ave, r_avo;
   logic [1:0]  r_type;
   logic [31:0] r_ae, r_ao;

   function automatic bit m_has(int v);
      for (int i = 0; i < ENT; i++)
         if (m_val[i] && m_vpn[i] == v) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void m_install(int v);
      m_vpn[m_ptr] = v;
      m_val[m_ptr] = 1'b1;
      m_ptr = (m_ptr + 1) % ENT;
   endfunction

   function automatic void m_flush();
      for (int i = 0; i < ENT; i++) m_val[i] = 1'b0;
   endfunction

   // Walks the model until both pages translate, recording walk order.
   function automatic void m_predict(int ve, int vo);
      exp_q.delete();
      for (int k = 0; k < 10; k++) begin
         if ((m_has(ve) && !pt_x[ve]) || (m_has(vo) && !pt_x[vo])) break;
         if (!m_has(ve)) begin
            exp_q.push_back(ve);
            if (pt_fault[ve]) break;
            m_install(ve);
         end else if (!m_has(vo)) begin
            exp_q.push_back(vo);
            if (pt_fault[vo]) break;
            m_install(vo);
         end else break;
      end
   endfunction

   function automatic logic [31:0] exp_addr(int v, logic [25:0] c);
      return {pt_ppn[v], c[5:0], 6'b0};
   endfunction

   task automatic clear_ptw();
      ptw_req_ready  = 1'b0;
      ptw_resp_valid = 1'b0;
      ptw_resp_ppn   = '0;
      ptw_resp_pcd   = 1'b0;
      ptw_resp_x     = 1'b0;
      ptw_resp_fault = 1'b0;
   endtask

   task automatic respond(int v);
      ptw_resp_valid = 1'b1;
      ptw_resp_ppn   = pt_ppn[v];
      ptw_resp_pcd   = pt_pcd[v];
      ptw_resp_x     = pt_x[v];
      ptw_resp_fault = pt_fault[v];
   endtask

   // Holds a lookup and serves walks until a hit or exception returns.
   task automatic run(input logic [25:0] e, input logic [25:0] o);
      bit prev_rdy, done, wst;
      int cyc, dly, wv;
      walked_q.delete();
      clc_even_in = e;
      clc_odd_in  = o;
      valid_in    = 1'b1;
      prev_rdy = lookup_ready;
      done = 0; wst = 0; cyc = 0; dly = 0; wv = 0;
      while (!done) begin
         @(negedge clk);
         clear_ptw();
         if (prev_rdy && (hit || exception)) begin
            done = 1;
            r_hit = hit; r_pcd = pcd; r_exc = exception;
            r_type = exception_type; r_ae = addr_even; r_ao = addr_odd;
            r_ave = addr_even_valid; r_avo = addr_odd_valid;
         end else if (wst) begin
            if (dly == 0) begin
               respond(wv);
               wst = 0;
            end else dly--;
         end else if (ptw_req_valid && $urandom_range(0, 1) == 1) begin
            ptw_req_ready = 1'b1;
            wv = int'(ptw_req_vpn[5:0]);
            walked_q.push_back(int'(ptw_req_vpn));
            wst = 1;
            dly = $urandom_range(0, 2);
         end
         prev_rdy = lookup_ready;
         cyc++;
         if (!done && cyc > 100) begin
            total++; bad++;
            $display("FAIL run_timeout: no result for clc %h/%h", e, o);
            done = 1;
            r_hit = 0; r_pcd = 0; r_exc = 0; r_type = 0;
            r_ae = 0; r_ao = 0; r_ave = 0; r_avo = 0;
         end
      end
      valid_in = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      m_flush();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      valid_in = 1'b0; flush = 1'b0;
      clc_even_in = '0; clc_odd_in = '0;
      clear_ptw();
      m_flush(); m_ptr = 0;
      repeat (3) @(negedge clk);
      total++; if (lookup_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", lookup_ready); end
      total++; if ({hit, pcd, exception, addr_even_valid, addr_odd_valid} !== 5'b0) begin bad++; $display("FAIL rst_flags: got %b want 0", {hit, pcd, exception, addr_even_valid, addr_odd_valid}); end
      total++; if ({addr_even, addr_odd, exception_type} !== 66'b0) begin bad++; $display("FAIL rst_addr: got %h %h %h want 0", addr_even, addr_odd, exception_type); end
      total++; if ({ptw_req_valid, ptw_req_vpn} !== 21'b0) begin bad++; $display("FAIL rst_ptw: got %b %h want 0", ptw_req_valid, ptw_req_vpn); end
      rst = 1'b1;
      @(negedge clk);
      total++; if (lookup_ready !== 1'b1 || hit !== 1'b0) begin bad++; $display("FAIL post_rst: ready %b hit %b want 1 0", lookup_ready, hit); end
   endtask

   task automatic test_first_miss();
      valid_in = 1'b1;
      clc_even_in = 26'h0000040;
      clc_odd_in  = 26'h0000041;
      @(negedge clk);
      total++; if (lookup_ready !== 1'b0) begin bad++; $display("FAIL miss_ready: got %b want 0", lookup_ready); end
      total++; if (ptw_req_valid !== 1'b1 || ptw_req_vpn !== 20'h00001) begin bad++; $display("FAIL miss_req: got %b %h want 1 00001", ptw_req_valid, ptw_req_vpn); end
      total++; if (hit !== 1'b0) begin bad++; $display("FAIL miss_hit: got %b want 0", hit); end
      ptw_req_ready = 1'b1;
      @(negedge clk);
      clear_ptw();
      respond(1);
      @(negedge clk);
      clear_ptw();
      total++; if (lookup_ready !== 1'b1) begin bad++; $display("FAIL fill_ready: got %b want 1", lookup_ready); end
      @(negedge clk);
      valid_in = 1'b0;
      m_install(1);
      total++; if (hit !== 1'b1 || exception !== 1'b0) begin bad++; $display("FAIL replay_hit: got %b %b want 1 0", hit, exception); end
      total++; if (addr_even !== 32'h80001000) begin bad++; $display("FAIL replay_even: got %h want 80001000", addr_even); end
      total++; if (addr_odd !== 32'h80001040) begin bad++; $display("FAIL replay_odd: got %h want 80001040", addr_odd); end
      total++; if ({addr_even_valid, addr_odd_valid} !== 2'b11) begin bad++; $display("FAIL replay_valid: got %b want 11", {addr_even_valid, addr_odd_valid}); end
   endtask

   task automatic test_page_cross();
      do_flush();
      m_predict(1, 2);
      run(26'h000007F, 26'h0000080);
      total++; if (walked_q.size() !== 2) begin bad++; $display("FAIL cross_walks: got %0d want 2", walked_q.size()); end
      else begin
         total++; if (walked_q[0] !== 1 || walked_q[1] !== 2) begin bad++; $display("FAIL cross_order: got %0d,%0d want 1,2", walked_q[0], walked_q[1]); end
      end
      total++; if (r_hit !== 1'b1) begin bad++; $display("FAIL cross_hit: got %b want 1", r_hit); end
      total++; if (r_ae !== 32'h80001FC0 || r_ao !== 32'h80002000) begin bad++; $display("FAIL cross_addr: got %h %h want 80001fc0 80002000", r_ae, r_ao); end
   endtask

   task automatic test_fault();
      pt_fault[9] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         m_predict(9, 9);
         run(26'h9 << 6, (26'h9 << 6) | 26'h1);
         total++; if (walked_q.size() !== 1 || walked_q[0] !== 9) begin bad++; $display("FAIL fault_walk%0d: got %0d walks want one of vpn 9", k, walked_q.size()); end
         total++; if (r_exc !== 1'b1 || r_type !== 2'd1) begin bad++; $display("FAIL fault_exc%0d: got %b/%0d want 1/1", k, r_exc, r_type); end
         total++; if (r_hit !== 1'b0) begin bad++; $display("FAIL fault_hit%0d: got %b want 0", k, r_hit); end
      end
      pt_fault[9] = 1'b0;
   endtask

   task automatic test_xviol();
      pt_x[10] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_predict(10, 10);
         run(26'hA << 6, (26'hA << 6) | 26'h1);
         total++; if (walked_q.size() !== exp_q.size()) begin bad++; $display("FAIL xv_walks%0d: got %0d want %0d", k, walked_q.size(), exp_q.size()); end
         total++; if (r_exc !== 1'b1 || r_type !== 2'd2) begin bad++; $display("FAIL xv_exc%0d: got %b/%0d want 1/2", k, r_exc, r_type); end
         total++; if ({r_hit, r_ave, r_avo} !== 3'b0) begin bad++; $display("FAIL xv_valid%0d: got %b want 000", k, {r_hit, r_ave, r_avo}); end
      end
      total++; if (walked_q.size() !== 0) begin bad++; $display("FAIL xv_nowalk: got %0d want 0", walked_q.size()); end
      pt_x[10] = 1'b1;
   endtask

   task automatic test_flush_wait();
      int n;
      m_predict(5, 5);
      run(26'h5 << 6, 26'h5 << 6);
      valid_in = 1'b1;
      clc_even_in = 26'h6 << 6;
      clc_odd_in  = 26'h6 << 6;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ptw_req_valid && n < 10);
      total++; if (ptw_req_valid !== 1'b1) begin bad++; $display("FAIL fw_req: got %b want 1", ptw_req_valid); end
      ptw_req_ready = 1'b1;
      valid_in = 1'b0;
      @(negedge clk);
      clear_ptw();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      m_flush();
      total++; if (lookup_ready !== 1'b0) begin bad++; $display("FAIL fw_drain: got ready %b want 0", lookup_ready); end
      respond(6);
      @(negedge clk);
      clear_ptw();
      total++; if (lookup_ready !== 1'b1) begin bad++; $display("FAIL fw_idle: got ready %b want 1", lookup_ready); end
      m_predict(5, 5);
      run(26'h5 << 6, 26'h5 << 6);
      total++; if (walked_q.size() !== 1) begin bad++; $display("FAIL fw_old: got %0d walks want 1", walked_q.size()); end
      m_predict(6, 6);
      run(26'h6 << 6, 26'h6 << 6);
      total++; if (walked_q.size() !== 1 || r_hit !== 1'b1) begin bad++; $display("FAIL fw_new: got %0d walks hit %b want 1 1", walked_q.size(), r_hit); end
   endtask

   task automatic test_round_robin();
      logic [25:0] c;
      do_flush();
      for (int v = 20; v < 25; v++) begin
         c = 26'(v) << 6;
         m_predict(v, v);
         run(c, c | 26'h5);
      end
      for (int v = 21; v < 25; v++) begin
         c = 26'(v) << 6;
         m_predict(v, v);
         run(c, c | 26'h5);
         total++; if (walked_q.size() !== 0 || r_hit !== 1'b1) begin bad++; $display("FAIL rr_keep%0d: got %0d walks hit %b want 0 1", v, walked_q.size(), r_hit); end
      end
      m_predict(20, 20);
      run(26'd20 << 6, (26'd20 << 6) | 26'h5);
      total++; if (walked_q.size() !== 1 || exp_q.size() !== 1) begin bad++; $display("FAIL rr_evict: got %0d walks want 1", walked_q.size()); end
   endtask

   task automatic test_reset_mid_walk();
      int n;
      valid_in = 1'b1;
      clc_even_in = 26'd30 << 6;
      clc_odd_in  = 26'd30 << 6;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ptw_req_valid && n < 10);
      ptw_req_ready = 1'b1;
      @(negedge clk);
      clear_ptw();
      valid_in = 1'b0;
      rst = 1'b0;
      m_flush(); m_ptr = 0;
      @(negedge clk);
      rst = 1'b1;
      respond(30);
      total++; if (lookup_ready !== 1'b1 || ptw_req_valid !== 1'b0) begin bad++; $display("FAIL rmw_state: got %b %b want 1 0", lookup_ready, ptw_req_valid); end
      @(negedge clk);
      clear_ptw();
      total++; if (lookup_ready !== 1'b1 || hit !== 1'b0) begin bad++; $display("FAIL rmw_ignore: got %b %b want 1 0", lookup_ready, hit); end
      m_predict(5, 30);
      run(26'h5 << 6, 26'd30 << 6);
      total++; if (walked_q.size() !== 2 || r_hit !== 1'b1) begin bad++; $display("FAIL rmw_lost: got %0d walks hit %b want 2 1", walked_q.size(), r_hit); end
   endtask

   task automatic test_random();
      logic [25:0] e, o;
      logic [5:0]  lip;
      int ve, vo;
      for (int v = 32; v < 40; v++) begin
         pt_ppn[v] = 20'($urandom);
         pt_pcd[v] = 1'($urandom_range(0, 1));
      end
      for (int it = 0; it < 40; it++) begin
         ve  = $urandom_range(32, 39);
         lip = 6'($urandom_range(0, 63));
         e   = {20'(ve), lip};
         o   = e + 26'd1;
         vo  = int'(o[25:6]);
         m_predict(ve, vo);
         run(e, o);
         total++; if (walked_q != exp_q) begin bad++; $display("FAIL rnd_walks%0d: got %0d walks want %0d", it, walked_q.size(), exp_q.size()); end
         total++; if (r_hit !== 1'b1 || r_exc !== 1'b0) begin bad++; $display("FAIL rnd_hit%0d: got %b %b want 1 0", it, r_hit, r_exc); end
         total++; if (r_ae !== exp_addr(ve, e) || r_ao !== exp_addr(vo, o)) begin bad++; $display("FAIL rnd_addr%0d: got %h %h want %h %h", it, r_ae, r_ao, exp_addr(ve, e), exp_addr(vo, o)); end
         total++; if (r_pcd !== (pt_pcd[ve] | pt_pcd[vo])) begin bad++; $display("FAIL rnd_pcd%0d: got %b want %b", it, r_pcd, pt_pcd[ve] | pt_pcd[vo]); end
      end
   endtask

   initial begin
      for (int v = 0; v < 64; v++) begin
         pt_ppn[v]   = 20'h80000 + 20'(v);
         pt_pcd[v]   = 1'b0;
         pt_x[v]     = 1'b1;
         pt_fault[v] = 1'b0;
      end
      test_reset();
      test_first_miss();
      test_page_cross();
      test_fault();
      test_xviol();
      test_flush_wait();
      test_round_robin();
      test_reset_mid_walk();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/f1_itlb.md
# f1_itlb

Parametrised instruction TLB for the F1 fetch stage. Each cycle it translates the even and odd cache-line addresses (CLC) to physical line addresses through a fully associative, round-robin-replaced array. On a miss it stalls fetch, issues a page-walk request, installs the returned entry, and reports page faults and execute-permission violations per port. Flush support covers sfence/satp changes. It replaces the fixed, fill-less single-cycle TLB currently instantiated in F1.

## Interface
- XLEN, 32: virtual and physical address width.
- CLC_WIDTH, 26: cache-line address width; LINE_OFF = XLEN-CLC_WIDTH (6).
- PAGE_OFF, 12: page offset bits; VPN_W = PPN_W = XLEN-PAGE_OFF.
- ENTRIES, 8: TLB entries, power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- valid_in  in  1  lookup request; inputs must be held while lookup_ready=0.
- clc_even_in  in  CLC_WIDTH  even line address.
- clc_odd_in  in  CLC_WIDTH  odd line address.
- flush  in  1  invalidate all entries.
- lookup_ready  out  1  1 when FSM is IDLE.
- hit  out  1  both ports translated, no exception.
- pcd  out  1  OR of the hit entries' pcd bits.
- exception  out  1  fault on either port.
- exception_type  out  2  0 none, 1 page fault, 2 exec violation (even port has priority).
- addr_even, addr_odd  out  XLEN  {PPN, line-in-page bits, LINE_OFF zeros}.
- addr_even_valid, addr_odd_valid  out  1  per-port translation valid.
- ptw_req_valid  out  1  walk request.
- ptw_req_ready  in  1  walker accepts.
- ptw_req_vpn  out  VPN_W  VPN to walk.
- ptw_resp_valid  in  1  walk result, single-cycle pulse.
- ptw_resp_ppn  in  PPN_W  result PPN.
- ptw_resp_pcd, ptw_resp_x, ptw_resp_fault  in  1 each  uncacheable, executable, fault.

## Operation
- VPN = clc[CLC_WIDTH-1 : PAGE_OFF-LINE_OFF]; line-in-page bits = clc[PAGE_OFF-LINE_OFF-1:0]. Both ports are compared against all valid entries in parallel.
- Entry fields: valid, vpn, ppn, pcd, x.
- Per-port hit with x=1 sets addr_*_valid. Hit with x=0 sets exception=1, type=2, with no walk.
- FSM states:
  - IDLE: valid_in with a miss on any port → REQ, latching the VPN. The even miss is serviced first; the odd port is serviced on replay.
  - REQ: ptw_req_valid=1 and VPN stable. On ptw_req_ready → WAIT.
  - WAIT: on ptw_resp_valid, if fault=0, write the entry at the round-robin pointer, increment the pointer (wraps at ENTRIES-1), → IDLE. If fault=1, nothing is installed; the next output cycle reports exception=1, type=1 for the port whose VPN matches the latched VPN, then → IDLE.
  - DRAIN: discard the next ptw_resp_valid, → IDLE.
- Flush clears all valid bits in one cycle; the pointer is unchanged.
  - IDLE or REQ without handshake: → IDLE and drop ptw_req_valid.
  - WAIT: → DRAIN.
  - flush with ptw_resp_valid in the same cycle: flush wins, no install, → IDLE.
- Fill with a VPN already present (impossible by construction) is not checked.
- Replay: upstream holds its inputs. The first IDLE cycle after a fill re-looks-up and hits.

## Timing
- Lookup latency is 1 cycle. Outputs are registered from the cycle-N inputs and are visible in cycle N+1.
- Outputs with valid_in=0 or lookup_ready=0: hit, valid, and exception are all 0.
- Minimum miss penalty: REQ (1) + WAIT (≥1) + replay (1) cycles.
- Reset values:
  - all outputs 0; lookup_ready=1;
  - FSM IDLE, all entries invalid, pointer 0.
- Reset mid-walk: state is lost. A walker response that arrives later is ignored, because the FSM is IDLE.

## Structure
- Shared package f1_pkg holds:
  - the exception_type encodings (EXC_NONE, EXC_PF, EXC_X);
  - the FSM state enum;
  - the tlb_entry_t struct.
- One sub-module, itlb_cam: entry storage, dual compare ports, and the write port. The FSM and output registers live in f1_itlb.

## Test plan
- Reset, then valid_in with clc_even=0x0000040, clc_odd=0x0000041 → miss, ptw_req_vpn=0x00001, lookup_ready=0.
- Respond with ppn=0x80001, x=1, pcd=0 → the replay cycle gives hit=1, addr_even=0x80001000, addr_odd=0x80001040.
- Page-crossing pair clc_even=0x000007F, clc_odd=0x0000080, both unmapped → two sequential walks (VPN 0x00001 then 0x00002), hit after the second replay.
- Walk response with fault=1 → exception=1, exception_type=1, no install; re-lookup misses again.
- Entry installed with x=0 → exception_type=2, no ptw_req_valid.
- flush asserted while in WAIT → response discarded, previously mapped VPN misses. With ENTRIES=4, fill 5 distinct VPNs → the first VPN misses and the other four hit.
